// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage
// and its IF/ID pipeline register.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC  = 32'hBFC00000;
  localparam logic [31:0] NOP_INSTR = 32'h00000000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } fstate_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_pipe_reg_en.sv
// Resettable register with load enable, used for the IF/ID
// pipeline register.
module pipe_reg_en #(
  parameter int         W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with a single outstanding SRAM request,
// a one-word buffer, delay-slot redirects and the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = fetch_stage_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        branch_takenD,
  input  logic [31:0] branch_targetD,
  input  logic        jumpD,
  input  logic [31:0] jump_targetD,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pc_plus4D,
  output logic        validD,
  output logic        fetch_busy
);

  import fetch_stage_pkg::*;

  localparam if_id_t BUBBLE = '{
    instr: NOP_INSTR, pc: 32'h0,
    pc_plus4: 32'h0, valid: 1'b0
  };

  fstate_e     state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic        buf_valid_q, buf_valid_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        discard_q, discard_d;
  logic        req_en_q, req_en_d;

  logic        adv, redirect;
  logic [31:0] target, next_pc;
  logic        d_en;
  if_id_t      d_d, d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      buf_q        <= NOP_INSTR;
      buf_valid_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'h0;
      discard_q    <= 1'b0;
      req_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      buf_q        <= buf_d;
      buf_valid_q  <= buf_valid_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      discard_q    <= discard_d;
      req_en_q     <= req_en_d;
    end
  end

  // A flush keeps the buffered word; it is delivered later
  always_comb begin
    adv      = buf_valid_q & ~stallD & ~flushD;
    redirect = d_q.valid & ~stallD
             & (jumpD | branch_takenD);
    target   = jumpD ? jump_targetD : branch_targetD;
    if (redirect)          next_pc = target;
    else if (pend_valid_q) next_pc = pend_pc_q;
    else                   next_pc = pc_q + 32'd4;
  end

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    discard_d   = discard_q;
    req_en_d    = 1'b1;
    inst_req    = 1'b0;
    unique case (state_q)
      S_REQ: begin
        inst_req = req_en_q;
        if (req_en_q & inst_addr_ok) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            buf_d       = inst_rdata;
            buf_valid_d = 1'b1;
            state_d     = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (adv) begin
          buf_valid_d = 1'b0;
          state_d     = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    pc_d         = adv ? next_pc : pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    if (adv) begin
      pend_valid_d = 1'b0;
    end else if (redirect) begin
      pend_valid_d = 1'b1;
      pend_pc_d    = target;
    end
  end

  always_comb begin
    d_en = flushD | ~stallD;
    d_d  = BUBBLE;
    if (adv) begin
      d_d.instr    = buf_q;
      d_d.pc       = pc_q;
      d_d.pc_plus4 = pc_q + 32'd4;
      d_d.valid    = 1'b1;
    end
  end

  pipe_reg_en #(
    .W       ($bits(if_id_t)),
    .RST_VAL (BUBBLE)
  ) u_if_id (
    .clk (clk),
    .rst (rst),
    .en  (d_en),
    .d   (d_d),
    .q   (d_q)
  );

  assign inst_addr  = pc_q;
  assign instrD     = d_q.instr;
  assign pcD        = d_q.pc;
  assign pc_plus4D  = d_q.pc_plus4;
  assign validD     = d_q.valid;
  assign fetch_busy = ~stallD & ~buf_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: table of per-cycle vectors
// plus hand sequences for latency, stall, flush, reset, wrap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallD, flushD;
  logic        branch_takenD, jumpD;
  logic [31:0] branch_targetD, jump_targetD;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic [31:0] instrD, pcD, pc_plus4D;
  logic        validD, fetch_busy;

  int ncmp = 0;
  int nbad = 0;

  logic        sram_pend;
  int          sram_cnt;
  int          dly;
  logic [31:0] sram_addr;
  int          dup_req = 0;
  int          hit10   = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stallD         (stallD),
    .flushD         (flushD),
    .branch_takenD  (branch_takenD),
    .branch_targetD (branch_targetD),
    .jumpD          (jumpD),
    .jump_targetD   (jump_targetD),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .instrD         (instrD),
    .pcD            (pcD),
    .pc_plus4D      (pc_plus4D),
    .validD         (validD),
    .fetch_busy     (fetch_busy)
  );

  // SRAM model: accepts at once, returns ~addr after dly cycles
  assign inst_addr_ok = inst_req;
  assign inst_data_ok = sram_pend && (sram_cnt == 0);
  assign inst_rdata   = ~sram_addr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_pend <= 1'b0;
      sram_cnt  <= 0;
      sram_addr <= 32'h0;
    end else if (inst_req && inst_addr_ok) begin
      sram_pend <= 1'b1;
      sram_cnt  <= dly;
      sram_addr <= inst_addr;
    end else if (sram_pend) begin
      if (sram_cnt == 0) sram_pend <= 1'b0;
      else               sram_cnt  <= sram_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (!rst && inst_req && sram_pend) dup_req++;
    if (!rst && inst_req && inst_addr == 32'hBFC00010) hit10++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_d(input string nm, input logic [31:0] pc);
    chk({nm, ".valid"}, {31'h0, validD}, 32'h1);
    chk({nm, ".pc"}, pcD, pc);
    chk({nm, ".instr"}, instrD, ~pc);
    chk({nm, ".pc4"}, pc_plus4D, pc + 32'd4);
  endtask

  typedef struct {
    logic        stall;
    logic        jump;
    logic [31:0] jtgt;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_busy;
  } vec_t;

  vec_t tv [1:19];

  initial begin
    for (int i = 1; i <= 19; i++)
      tv[i] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1};
    tv[4]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC00000, 1'b0};
    tv[7]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC00004, 1'b0};
    tv[10] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC00008, 1'b0};
    tv[11] = '{1'b0, 1'b1, 32'hBFC00100, 1'b0, 32'h0, 1'b1};
    tv[13] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0000C, 1'b0};
    tv[16] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC00100, 1'b0};
    tv[19] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC00104, 1'b0};

    rst = 1'b1;
    stallD = 1'b0; flushD = 1'b0;
    branch_takenD = 1'b0; jumpD = 1'b0;
    branch_targetD = 32'h0; jump_targetD = 32'h0;
    dly = 0;
    #1;
    chk("rst.valid", {31'h0, validD}, 32'h0);
    chk("rst.instr", instrD, 32'h0);
    chk("rst.pc", pcD, 32'h0);
    chk("rst.pc4", pc_plus4D, 32'h0);
    chk("rst.req", {31'h0, inst_req}, 32'h0);
    chk("rst.addr", inst_addr, 32'hBFC00000);
    step();
    rst = 1'b0;

    // steady fetch, then jump at pcD=BFC00008
    for (int i = 1; i <= 19; i++) begin
      stallD = tv[i].stall;
      jumpD  = tv[i].jump;
      jump_targetD = tv[i].jtgt;
      #1;
      chk($sformatf("v%0d.busy", i), {31'h0, fetch_busy},
          {31'h0, tv[i].exp_busy});
      step();
      chk($sformatf("v%0d.valid", i), {31'h0, validD},
          {31'h0, tv[i].exp_valid});
      chk($sformatf("v%0d.instr", i), instrD,
          tv[i].exp_valid ? ~tv[i].exp_pc : 32'h0);
      if (tv[i].exp_valid) begin
        chk($sformatf("v%0d.pc", i), pcD, tv[i].exp_pc);
        chk($sformatf("v%0d.pc4", i), pc_plus4D,
            tv[i].exp_pc + 32'd4);
      end
    end
    jumpD = 1'b0;

    // data_ok four cycles late
    dly = 4;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("slow%0d.valid", k), {31'h0, validD}, 32'h0);
      chk($sformatf("slow%0d.instr", k), instrD, 32'h0);
      chk($sformatf("slow%0d.busy", k), {31'h0, fetch_busy}, 32'h1);
      chk($sformatf("slow%0d.req", k), {31'h0, inst_req}, 32'h0);
    end
    dly = 0;
    step();
    step();
    chk_d("slow.out", 32'hBFC00108);

    // stall while the next word is buffered
    stallD = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_d($sformatf("stall%0d", k), 32'hBFC00108);
      chk($sformatf("stall%0d.req", k), {31'h0, inst_req}, 32'h0);
      chk($sformatf("stall%0d.busy", k), {31'h0, fetch_busy}, 32'h0);
    end
    stallD = 1'b0;
    step();
    chk_d("unstall", 32'hBFC0010C);

    // flush together with stall, buffered word kept
    stallD = 1'b1;
    step();
    step();
    chk_d("pre_flush", 32'hBFC0010C);
    flushD = 1'b1;
    step();
    chk("flush.valid", {31'h0, validD}, 32'h0);
    chk("flush.instr", instrD, 32'h0);
    flushD = 1'b0;
    stallD = 1'b0;
    step();
    chk_d("post_flush", 32'hBFC00110);

    // asynchronous reset while in S_WAIT
    dly = 3;
    step();
    #1 rst = 1'b1;
    #1;
    chk("arst.valid", {31'h0, validD}, 32'h0);
    chk("arst.instr", instrD, 32'h0);
    chk("arst.pc", pcD, 32'h0);
    chk("arst.req", {31'h0, inst_req}, 32'h0);
    chk("arst.addr", inst_addr, 32'hBFC00000);
    #1 rst = 1'b0;
    dly = 0;
    step();
    chk("arst.req1", {31'h0, inst_req}, 32'h1);
    chk("arst.addr1", inst_addr, 32'hBFC00000);
    step();
    step();
    step();
    chk_d("arst.first", 32'hBFC00000);

    // jump beats branch; target wraps past 2^32
    jumpD = 1'b1; jump_targetD = 32'hFFFFFFFC;
    branch_takenD = 1'b1; branch_targetD = 32'h12345678;
    step();
    jumpD = 1'b0; branch_takenD = 1'b0;
    step();
    step();
    chk_d("dslot", 32'hBFC00004);
    step();
    step();
    step();
    chk_d("wrap", 32'hFFFFFFFC);

    // redirect and advance on the same edge, misaligned target
    stallD = 1'b1;
    branch_takenD = 1'b1; branch_targetD = 32'h00000203;
    step();
    step();
    chk_d("hold2", 32'hFFFFFFFC);
    stallD = 1'b0;
    step();
    branch_takenD = 1'b0;
    chk_d("zero", 32'h00000000);
    chk("same.req", {31'h0, inst_req}, 32'h1);
    chk("same.addr", inst_addr, 32'h00000203);
    step();
    step();
    step();
    chk_d("misal", 32'h00000203);

    chk("no_req_in_wait", dup_req, 0);
    chk("no_bfc00010", hit10, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
